// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared mode encodings and tick divisor helper for the LED sequencer
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_BOUNCE = 2'b00,
      MODE_ROT_R  = 2'b01,
      MODE_ROT_L  = 2'b10,
      MODE_BAR    = 2'b11
   } mode_e;

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - base tick prescaler, pulses tick while parked on its last count
module tick_divider
   import led_seq_pkg::*;
#(
   parameter int CLK_HZ  = 12000000,
   parameter int TICK_HZ = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern sequencer (bounce / rotate / bar) with step and wrap pulses
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int N_LEDS  = 8,
   parameter int CLK_HZ  = 12000000,
   parameter int TICK_HZ = 1000,
   parameter int SPD_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [SPD_W-1:0]  speed,
   input  logic              restart,
   output logic [N_LEDS-1:0] leds,
   output logic              step,
   output logic              wrap
);

   localparam int PW = $clog2(N_LEDS + 1);
   localparam logic [PW-1:0] TOP    = PW'(N_LEDS - 1);
   localparam logic [PW-1:0] TOP_M1 = PW'(N_LEDS - 2);
   localparam logic [PW-1:0] FULL   = PW'(N_LEDS);

   // pos_q is the lit index for one-hot modes and the fill level for bar;
   // dir_q means "descending" in bounce and "emptying" in bar.
   mode_e             mode_in, mode_q, mode_d;
   logic [PW-1:0]     pos_q, pos_d;
   logic              dir_q, dir_d;
   logic [SPD_W-1:0]  cnt_q, cnt_d;
   logic [N_LEDS-1:0] leds_q, leds_d;
   logic              step_q, step_d, wrap_q, wrap_d;
   logic              tick, step_fire;

   assign mode_in = mode_e'(mode);

   tick_divider #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (restart),
      .tick (tick)
   );

   function automatic logic [PW-1:0] start_pos(input mode_e m);
      return (m == MODE_BOUNCE || m == MODE_ROT_R) ? TOP : '0;
   endfunction

   function automatic logic start_dir(input mode_e m);
      return (m == MODE_BOUNCE);
   endfunction

   function automatic logic [N_LEDS-1:0] decode(input mode_e m, input logic [PW-1:0] p);
      if (m == MODE_BAR) return ~({N_LEDS{1'b1}} >> p);
      return N_LEDS'(1) << p;
   endfunction

   always_comb begin
      mode_d    = mode_q;
      pos_d     = pos_q;
      dir_d     = dir_q;
      cnt_d     = cnt_q;
      step_d    = 1'b0;
      wrap_d    = 1'b0;
      step_fire = tick && (cnt_q >= speed);
      if (tick) cnt_d = step_fire ? '0 : cnt_q + SPD_W'(1);

      if (restart) begin
         mode_d = mode_in;
         pos_d  = start_pos(mode_in);
         dir_d  = start_dir(mode_in);
         cnt_d  = '0;
      end else if (mode_in != mode_q) begin
         mode_d = mode_in;
         pos_d  = start_pos(mode_in);
         dir_d  = start_dir(mode_in);
      end else if (step_fire) begin
         step_d = 1'b1;
         dir_d  = 1'b0;
         unique case (mode_q)
            MODE_BOUNCE: begin
               if (pos_q > TOP || (dir_q && pos_q == '0) || (!dir_q && pos_q == TOP)) begin
                  pos_d = TOP;
                  dir_d = 1'b1;
               end else if (dir_q) begin
                  pos_d = pos_q - PW'(1);
                  dir_d = (pos_q != PW'(1));
               end else begin
                  pos_d  = pos_q + PW'(1);
                  dir_d  = (pos_q == TOP_M1);
                  wrap_d = (pos_q == TOP_M1);
               end
            end
            MODE_ROT_R: begin
               if (pos_q > TOP) begin
                  pos_d = TOP;
               end else if (pos_q == '0) begin
                  pos_d  = TOP;
                  wrap_d = 1'b1;
               end else begin
                  pos_d = pos_q - PW'(1);
               end
            end
            MODE_ROT_L: begin
               if (pos_q >= TOP) begin
                  pos_d  = '0;
                  wrap_d = (pos_q == TOP);
               end else begin
                  pos_d = pos_q + PW'(1);
               end
            end
            MODE_BAR: begin
               if (pos_q > FULL || (!dir_q && pos_q == FULL) || (dir_q && pos_q == '0)) begin
                  pos_d = '0;
               end else if (!dir_q) begin
                  pos_d = pos_q + PW'(1);
                  dir_d = (pos_q == TOP);
               end else begin
                  pos_d  = pos_q - PW'(1);
                  dir_d  = (pos_q != PW'(1));
                  wrap_d = (pos_q == PW'(1));
               end
            end
            default: pos_d = start_pos(mode_q);
         endcase
      end
      leds_d = decode(mode_d, pos_d);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mode_q <= MODE_BOUNCE;
         pos_q  <= TOP;
         dir_q  <= 1'b1;
         cnt_q  <= '0;
         leds_q <= {1'b1, {(N_LEDS-1){1'b0}}};
         step_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
         pos_q  <= pos_d;
         dir_q  <= dir_d;
         cnt_q  <= cnt_d;
         leds_q <= leds_d;
         step_q <= step_d;
         wrap_q <= wrap_d;
      end
   end

   assign leds = leds_q;
   assign step = step_q;
   assign wrap = wrap_q;

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter N_LEDS, default 8: number of LEDs, legal range 2..32.
REQ-002 SHALL have parameter CLK_HZ, default 12000000: clk frequency in Hz.
REQ-003 SHALL have parameter TICK_HZ, default 1000: base tick rate; DIV = CLK_HZ/TICK_HZ, which must be at least 2.
REQ-004 SHALL have parameter SPD_W, default 8: width of the speed input.
REQ-005 SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port en  input  1  1 = run, 0 = pause (prescaler, step counter and pattern hold).
REQ-008 SHALL have port mode  input  2  00 bounce, 01 rotate-right, 10 rotate-left, 11 bar.
REQ-009 SHALL have port speed  input  SPD_W  base ticks per step minus 1.
REQ-010 SHALL have port restart  input  1  synchronous pattern restart.
REQ-011 SHALL have port leds  output  N_LEDS  registered LED pattern.
REQ-012 SHALL have port step  output  1  one-cycle pulse, coincident with each leds update caused by a step.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse, coincident with the step that returns the pattern to its start state.

Function
REQ-014 The prescaler SHALL count 0..DIV-1 while en=1 and SHALL emit an internal tick when it is at DIV-1.
REQ-015 The step counter SHALL advance on tick; a step SHALL occur on a tick when count >= speed, clearing the count; a speed change SHALL therefore take effect without lockup.
REQ-016 leds, step and wrap SHALL update one clk after the step condition; step period = DIV*(speed+1) cycles.
REQ-017 Bounce start state SHALL be the MSB one-hot; the lit bit moves toward the LSB, then back; each end SHALL be lit for exactly one step; period = 2*N_LEDS-2 steps.
REQ-018 Rotate-right start state SHALL be the MSB one-hot; shift right; the LSB wraps to the MSB; period = N_LEDS steps.
REQ-019 Rotate-left start state SHALL be the LSB one-hot; shift left; the MSB wraps to the LSB; period = N_LEDS steps.
REQ-020 Bar start state SHALL be all-zero; fill one bit per step from the MSB to all-ones, then empty from the LSB side back to zero; period = 2*N_LEDS steps.
REQ-021 A mode change (mode differs from its registered copy) SHALL load the new mode's start state on the next clk, without a step or wrap pulse; prescaler and step count continue.
REQ-022 restart=1 SHALL load the current mode's start state, clear prescaler and step count, and suppress step and wrap; it SHALL take priority over en and over a mode change.
REQ-023 With en=0, leds SHALL hold, step/wrap SHALL stay 0, and no tick SHALL be lost or duplicated on resume.
REQ-024 Direction state SHALL never desynchronise from position; an invalid internal state SHALL recover to the mode's start state on the next step.

Reset
REQ-025 While rst=0 at posedge clk: leds = MSB one-hot, step = 0, wrap = 0, prescaler = 0, step count = 0, registered mode = 00 (bounce).
REQ-026 rst SHALL take priority over restart, en and mode; reset mid-pattern SHALL fully reinitialise on the next clk.
REQ-027 The first step after reset release SHALL occur exactly DIV*(speed+1) cycles later, provided en=1.

Structure
REQ-028 Mode encodings and the DIV computation SHALL live in shared package led_seq_pkg.
REQ-029 The prescaler SHALL be sub-module tick_divider (params CLK_HZ, TICK_HZ; ports clk, rst, en, clr, tick).
REQ-030 Pattern state SHALL be position/level plus direction registers; leds SHALL be decoded and registered from them.

Verification (N_LEDS=4, CLK_HZ=8, TICK_HZ=2 → DIV=4, unless stated)
REQ-031 Hold rst=0 for 3 cycles, N_LEDS=8 -> leds=8'h80, step=0, wrap=0.
REQ-032 Bounce, speed=0 -> leds 8,4,2,1,2,4,8 changing every 4 cycles; wrap pulses only with the return to 8.
REQ-033 Rotate-left, speed=2 -> leds 1,2,4,8,1 every 12 cycles; wrap pulses with the return to 1.
REQ-034 Bar, speed=0 -> leds 0,8,C,E,F,E,C,8,0; wrap pulses with the return to 0.
REQ-035 en=0 for 20 cycles mid-bounce -> leds hold, no step; restart=1 during the pause -> leds=8 next cycle, first step 4 cycles after en=1.
REQ-036 Mode switch from rotate-right to bar while leds=2 -> leds=0 next clk, no step or wrap pulse that cycle.
